// File: rtl/spi_reg_writer_if.sv
// Register bus between the SPI register writer and pwm_peripheral.
// The writer drives five 8-bit configuration registers and a one-cycle commit strobe.
interface spi_reg_writer_if;
    logic [7:0] en_reg_out_7_0;
    logic [7:0] en_reg_out_15_8;
    logic [7:0] en_reg_pwm_7_0;
    logic [7:0] en_reg_pwm_15_8;
    logic [7:0] pwm_duty_cycle;
    logic       wr_strobe;

    modport master (
        output en_reg_out_7_0,
        output en_reg_out_15_8,
        output en_reg_pwm_7_0,
        output en_reg_pwm_15_8,
        output pwm_duty_cycle,
        output wr_strobe
    );

    modport slave (
        input en_reg_out_7_0,
        input en_reg_out_15_8,
        input en_reg_pwm_7_0,
        input en_reg_pwm_15_8,
        input pwm_duty_cycle,
        input wr_strobe
    );
endinterface

// File: rtl/spi_reg_writer.sv
// Write-only SPI mode-0 peripheral: 16-bit frames {wr, addr[6:0], data[7:0]}
// update the pwm_peripheral configuration registers on the closing ncs edge.
module spi_reg_writer #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic [6:0]  MAX_ADDR    = 7'h04
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sclk,
    input  logic             copi,
    input  logic             ncs,
    spi_reg_writer_if.master reg_bus
);

    typedef enum logic {
        ST_IDLE,
        ST_SHIFT
    } state_e;

    localparam logic [4:0] CNT_FULL = 5'd16;
    localparam logic [4:0] CNT_SAT  = 5'd17;

    logic [SYNC_STAGES-1:0] sclk_sync_q;
    logic [SYNC_STAGES-1:0] copi_sync_q;
    logic [SYNC_STAGES-1:0] ncs_sync_q;
    logic                   sclk_hist_q;
    logic                   ncs_hist_q;

    // NOTE: every flop here uses a synchronous reset, including the
    // synchronisers; ncs resets high so an idle bus never looks like a frame start.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sclk_sync_q <= '0;
            copi_sync_q <= '0;
            ncs_sync_q  <= '1;
            sclk_hist_q <= 1'b0;
            ncs_hist_q  <= 1'b1;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
            copi_sync_q <= {copi_sync_q[SYNC_STAGES-2:0], copi};
            ncs_sync_q  <= {ncs_sync_q[SYNC_STAGES-2:0], ncs};
            sclk_hist_q <= sclk_sync_q[SYNC_STAGES-1];
            ncs_hist_q  <= ncs_sync_q[SYNC_STAGES-1];
        end
    end

    logic sclk_s;
    logic copi_s;
    logic ncs_s;
    logic sclk_rise;
    logic ncs_fall;
    logic ncs_rise;

    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign copi_s    = copi_sync_q[SYNC_STAGES-1];
    assign ncs_s     = ncs_sync_q[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_hist_q;
    assign ncs_fall  = ~ncs_s & ncs_hist_q;
    assign ncs_rise  = ncs_s & ~ncs_hist_q;

    state_e      state_q;
    logic [15:0] shift_q;
    logic [4:0]  bit_cnt_q;
    logic [7:0]  en_out_lo_q;
    logic [7:0]  en_out_hi_q;
    logic [7:0]  en_pwm_lo_q;
    logic [7:0]  en_pwm_hi_q;
    logic [7:0]  duty_q;
    logic        wr_strobe_q;

    logic        commit_ok;
    assign commit_ok = (bit_cnt_q == CNT_FULL) && shift_q[15] && (shift_q[14:8] <= MAX_ADDR);

    // NOTE: sequential state is written with non-blocking assignments only, so
    // every branch below sees the values from before this clock edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            shift_q     <= '0;
            bit_cnt_q   <= '0;
            en_out_lo_q <= '0;
            en_out_hi_q <= '0;
            en_pwm_lo_q <= '0;
            en_pwm_hi_q <= '0;
            duty_q      <= '0;
            wr_strobe_q <= 1'b0;
        end else begin
            wr_strobe_q <= 1'b0;
            if (ncs_fall) begin
                // Arming wins over a coincident sclk rise: the count stays 0.
                state_q   <= ST_SHIFT;
                shift_q   <= '0;
                bit_cnt_q <= '0;
            end else begin
                case (state_q)
                    ST_SHIFT: begin
                        if (ncs_rise) begin
                            state_q <= ST_IDLE;
                            if (commit_ok) begin
                                wr_strobe_q <= 1'b1;
                                case (shift_q[14:8])
                                    7'h00:   en_out_lo_q <= shift_q[7:0];
                                    7'h01:   en_out_hi_q <= shift_q[7:0];
                                    7'h02:   en_pwm_lo_q <= shift_q[7:0];
                                    7'h03:   en_pwm_hi_q <= shift_q[7:0];
                                    7'h04:   duty_q      <= shift_q[7:0];
                                    default: ;
                                endcase
                            end
                        end else if (sclk_rise && !ncs_s) begin
                            shift_q <= {shift_q[14:0], copi_s};
                            if (bit_cnt_q != CNT_SAT) begin
                                bit_cnt_q <= bit_cnt_q + 5'd1;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign reg_bus.en_reg_out_7_0  = en_out_lo_q;
    assign reg_bus.en_reg_out_15_8 = en_out_hi_q;
    assign reg_bus.en_reg_pwm_7_0  = en_pwm_lo_q;
    assign reg_bus.en_reg_pwm_15_8 = en_pwm_hi_q;
    assign reg_bus.pwm_duty_cycle  = duty_q;
    assign reg_bus.wr_strobe       = wr_strobe_q;

endmodule

// File: tb/tb_spi_reg_writer.sv
// Self-checking bench for spi_reg_writer: a register model pushes the expected
// register image per committing frame; a strobe monitor pops and compares it.
module tb_spi_reg_writer;

    logic clk;
    logic rst_n;
    logic sclk;
    logic copi;
    logic ncs;

    spi_reg_writer_if bus ();

    spi_reg_writer #(
        .SYNC_STAGES(2),
        .MAX_ADDR   (7'h04)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .sclk   (sclk),
        .copi   (copi),
        .ncs    (ncs),
        .reg_bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int raise_cyc = 0;
    int strobe_cnt = 0;
    logic prev_strobe = 1'b0;

    logic [7:0]  model [5];
    logic [39:0] exp_q [$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [39:0] got, input logic [39:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [39:0] dut_image();
        return {bus.pwm_duty_cycle, bus.en_reg_pwm_15_8, bus.en_reg_pwm_7_0,
                bus.en_reg_out_15_8, bus.en_reg_out_7_0};
    endfunction

    function automatic logic [39:0] model_image();
        return {model[4], model[3], model[2], model[1], model[0]};
    endfunction

    // Strobe monitor: every pulse must match the next queued register image,
    // arrive three clk edges after ncs was raised, and last one cycle.
    always @(negedge clk) begin
        if (bus.wr_strobe === 1'b1) begin
            strobe_cnt <= strobe_cnt + 1;
            check("strobe_width", {39'd0, prev_strobe}, 40'd0);
            check("strobe_expected", 40'(exp_q.size() != 0), 40'd1);
            if (exp_q.size() != 0) begin
                check("commit_regs", dut_image(), exp_q.pop_front());
                check("commit_latency", 40'(cyc - raise_cyc), 40'd3);
            end
        end
        prev_strobe <= bus.wr_strobe;
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bits(input logic [31:0] val, input int nbits);
        for (int i = nbits - 1; i >= 0; i--) begin
            copi = val[i];
            wait_clk(4);
            sclk = 1'b1;
            wait_clk(4);
            sclk = 1'b0;
        end
    endtask

    task automatic send_frame(input logic [31:0] val, input int nbits);
        logic [15:0] f;
        ncs = 1'b0;
        wait_clk(4);
        send_bits(val, nbits);
        wait_clk(4);
        f = val[15:0];
        if (nbits == 16 && f[15] && f[14:8] <= 7'h04) begin
            model[f[10:8]] = f[7:0];
            exp_q.push_back(model_image());
        end
        ncs = 1'b1;
        raise_cyc = cyc;
        wait_clk(8);
    endtask

    task automatic phase_check(input string tag, input int exp_strobes);
        check({tag, "_pending"}, 40'(exp_q.size()), 40'd0);
        check({tag, "_regs"}, dut_image(), model_image());
        check({tag, "_strobes"}, 40'(strobe_cnt), 40'(exp_strobes));
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 5; i++) model[i] = 8'h00;
        rst_n = 1'b0;
        sclk  = 1'b0;
        copi  = 1'b0;
        ncs   = 1'b1;
        wait_clk(4);
        check("rst_out_lo", {32'd0, bus.en_reg_out_7_0}, 40'd0);
        check("rst_out_hi", {32'd0, bus.en_reg_out_15_8}, 40'd0);
        check("rst_pwm_lo", {32'd0, bus.en_reg_pwm_7_0}, 40'd0);
        check("rst_pwm_hi", {32'd0, bus.en_reg_pwm_15_8}, 40'd0);
        check("rst_duty", {32'd0, bus.pwm_duty_cycle}, 40'd0);
        check("rst_strobe", {39'd0, bus.wr_strobe}, 40'd0);
        rst_n = 1'b1;
        wait_clk(6);

        send_frame(32'h80F0, 16);
        phase_check("first_write", 1);

        send_frame(32'h810F, 16);
        send_frame(32'h82AA, 16);
        send_frame(32'h8355, 16);
        send_frame(32'h8480, 16);
        phase_check("all_regs", 5);
        check("duty_value", {32'd0, bus.pwm_duty_cycle}, 40'h80);

        send_frame(32'h00FF, 16);
        send_frame(32'h85FF, 16);
        phase_check("read_and_bad_addr", 5);

        send_frame(32'h8233 >> 1, 15);
        send_frame(32'h08233, 17);
        phase_check("short_long", 5);
        send_frame(32'h8233, 16);
        phase_check("after_bad_len", 6);

        // Reset in the middle of a frame, release with ncs still low.
        ncs = 1'b0;
        wait_clk(4);
        send_bits(32'h81, 8);
        rst_n = 1'b0;
        wait_clk(2);
        for (int i = 0; i < 5; i++) model[i] = 8'h00;
        rst_n = 1'b1;
        wait_clk(2);
        send_bits(32'h11, 8);
        wait_clk(4);
        ncs = 1'b1;
        raise_cyc = cyc;
        wait_clk(8);
        phase_check("mid_frame_reset", 6);
        send_frame(32'h8101, 16);
        phase_check("after_reset", 7);

        for (int i = 0; i < 5; i++) begin
            copi = i[0];
            sclk = 1'b1;
            wait_clk(4);
            sclk = 1'b0;
            wait_clk(4);
        end
        phase_check("stray_sclk", 7);
        send_frame(32'h84C3, 16);
        wait_clk(10);
        phase_check("after_stray", 8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
